upscale_2x: RTL and testbench
=============================

UPSCALE_2X -- requirements
Module: upscale_2x

Interface
REQ-001 Parameter IN_W, default 320, input pixels per line.
REQ-002 Parameter IN_H, default 240, input lines per frame.
REQ-003 clk_r  input  1  single clock, same domain as the upstream FIFO read side; one clock; reset is asynchronous and active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 din  input  17  upstream FIFO read data; [15:0] RGB565 (R[15:11], G[10:5], B[4:0]), [16] ignored.
REQ-006 data_count_r  input  10  upstream FIFO fill level.
REQ-007 rd_fifo  output  1  upstream FIFO read strobe; one pixel per asserted cycle.
REQ-008 out_pix  output  17  output pixel; [15:0] RGB565, [16] = start-of-frame flag.
REQ-009 out_valid / out_ready  output 1 / input 1  output handshake; transfer when both are high.
REQ-010 out_eol  output  1  high with the last pixel of each output line.
REQ-011 frame_done  output  1  one-cycle pulse after the last output pixel of a frame transfers.

Function
REQ-012 Output is 2*IN_W x 2*IN_H: each input line is emitted twice, and each input pixel is emitted as two horizontal pixels.
REQ-013 FSM states: IDLE -> FILL -> EMIT0 -> EMIT1 -> FILL (next line); IDLE leaves on the first cycle after reset.
REQ-014 FILL: rd_fifo is high only when data_count_r >= 2 and fewer than IN_W reads were issued for this line; din is valid one cycle after rd_fifo and is written to line_buffer at the input column.
REQ-015 FILL -> EMIT0 once the IN_W-th pixel is written; no reads are issued in EMIT0/EMIT1, so backpressure on out_ready stalls the FIFO reads.
REQ-016 EMIT0/EMIT1: output column 0..2*IN_W-1; EMIT1 re-reads the same line_buffer contents.
REQ-017 While out_valid=1 and out_ready=0, out_pix, out_eol and out_valid hold stable; the line_buffer 1-cycle read latency is absorbed so that sustained out_ready=1 gives one pixel per cycle.
REQ-018 out_pix[16]=1 only on output pixel (0,0) of each frame.
REQ-019 After EMIT1 of input row IN_H-1, frame_done pulses on the cycle after the final transfer; the row counter wraps to 0 and the FSM returns to FILL.
REQ-020 Width rules: input column 9 bits, input row 8 bits, output column 10 bits, copy flag 1 bit; all counters wrap to 0 exactly at their limits.
REQ-021 data_count_r dropping below 2 mid-FILL pauses reads; the column count is preserved and filling resumes without pixel loss.

Reset
REQ-022 On rst_n low: state IDLE; all counters 0; rd_fifo, out_valid, out_eol, frame_done, out_pix = 0.
REQ-023 Reset mid-frame discards the partial line; the first pixel read after reset is row 0, column 0; upstream FIFO contents are not flushed.

Configuration
REQ-024 Macro UPSCALE_BILINEAR_H_EN.
- Defined: output pixel 2k = p[k]; pixel 2k+1 = per-channel (p[k]+p[k+1])>>1, truncated, computed on 6-bit R/B and 7-bit G sums; pixel 2*IN_W-1 = p[IN_W-1].
- Undefined: pixels 2k and 2k+1 = p[k] (nearest neighbour).
- Vertical scaling is duplication in both builds.

Structure
REQ-025 Package upscale_pkg holds IN_W/IN_H defaults, OUT_W/OUT_H, the FSM state enum, and RGB565 field positions and widths.
REQ-026 Sub-module line_buffer: simple dual-port synchronous RAM, IN_W x 16, one write port, one read port with 1-cycle read latency.

Verification
REQ-027 Ramp frame, din[15:0] = column, data_count_r = 100 constant, out_ready = 1 -> 640x480 pixels; row r outputs column c = c>>1; frame_done pulses once.
REQ-028 out_ready toggled randomly at 50% -> output sequence identical to REQ-027; out_pix never changes while out_valid=1 and out_ready=0.
REQ-029 data_count_r held at 1 after 100 reads -> rd_fifo stays low; raise to 50 -> reads resume at column 100; output is correct.
REQ-030 UPSCALE_BILINEAR_H_EN, p[0]=16'hF800, p[1]=16'h0000 -> outputs F800, 7800, 0000; last output pixel of each line equals p[319].
REQ-031 rst_n pulsed low at input row 120 -> all outputs are 0 during reset; the next transferred pixel has out_pix[16]=1 and comes from the first post-reset read.
REQ-032 Two back-to-back frames -> out_eol on every 640th pixel; SOF flag only at pixels 0 and 307200.

Source files
------------

// File: rtl/upscale_pkg.sv
// Shared constants, FSM state type and RGB565 helpers for the 2x video upscaler.
package upscale_pkg;

    localparam int unsigned InWDefault  = 320;
    localparam int unsigned InHDefault  = 240;
    localparam int unsigned OutWDefault = 2 * InWDefault;
    localparam int unsigned OutHDefault = 2 * InHDefault;

    localparam int unsigned ColW   = 9;
    localparam int unsigned RowW   = 8;
    localparam int unsigned OcolW  = 10;
    localparam int unsigned PixW   = 16;
    localparam int unsigned DinW   = 17;
    localparam int unsigned CountW = 10;

    localparam int unsigned RLsb = 11;
    localparam int unsigned RW   = 5;
    localparam int unsigned GLsb = 5;
    localparam int unsigned GW   = 6;
    localparam int unsigned BLsb = 0;
    localparam int unsigned BW   = 5;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StEmit0,
        StEmit1
    } state_e;

    // Per-channel truncating mean of two RGB565 pixels.
    function automatic logic [PixW-1:0] avg565(input logic [PixW-1:0] a,
                                               input logic [PixW-1:0] b);
        logic [RW:0] r_sum;
        logic [GW:0] g_sum;
        logic [BW:0] b_sum;
        r_sum = {1'b0, a[RLsb +: RW]} + {1'b0, b[RLsb +: RW]};
        g_sum = {1'b0, a[GLsb +: GW]} + {1'b0, b[GLsb +: GW]};
        b_sum = {1'b0, a[BLsb +: BW]} + {1'b0, b[BLsb +: BW]};
        return {r_sum[RW:1], g_sum[GW:1], b_sum[BW:1]};
    endfunction

endpackage

// File: rtl/upscale_2x_if.sv
// Upstream FIFO read port and downstream pixel stream of the 2x upscaler.
interface upscale_2x_if;
    import upscale_pkg::*;

    logic [DinW-1:0]   din;
    logic [CountW-1:0] data_count_r;
    logic              rd_fifo;
    logic [DinW-1:0]   out_pix;
    logic              out_valid;
    logic              out_ready;
    logic              out_eol;
    logic              frame_done;

    modport master (
        input  din, data_count_r, out_ready,
        output rd_fifo, out_pix, out_valid, out_eol, frame_done
    );

    modport slave (
        output din, data_count_r, out_ready,
        input  rd_fifo, out_pix, out_valid, out_eol, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// Simple dual-port line RAM: one write port, one read port with 1-cycle read latency.
module line_buffer #(
    parameter int unsigned Depth = 320,
    parameter int unsigned AddrW = 9,
    parameter int unsigned DataW = 16
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/upscale_2x.sv
// 2x RGB565 upscaler: fills one line from the FIFO, then emits it twice at double width.
// Define UPSCALE_BILINEAR_H_EN for horizontal linear interpolation instead of duplication.
module upscale_2x
    import upscale_pkg::*;
#(
    parameter int unsigned IN_W = InWDefault,
    parameter int unsigned IN_H = InHDefault
) (
    input logic          clk_r,
    input logic          rst_n,
    upscale_2x_if.master bus_io
);

    localparam logic [ColW-1:0]  NumCol   = ColW'(IN_W);
    localparam logic [ColW-1:0]  LastCol  = ColW'(IN_W - 1);
    localparam logic [RowW-1:0]  LastRow  = RowW'(IN_H - 1);
    localparam logic [OcolW-1:0] LastOcol = OcolW'(2 * IN_W - 1);

    state_e state_q, state_d;
    logic fill, emit, rd_fifo, load, pass_end, odd, need_nxt, src_ok, sof, lb_re;
    logic [ColW-1:0]  rd_cnt_q, rd_cnt_d, wr_col_q, wr_col_d, fa_q, fa_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [OcolW-1:0] oc_q, oc_d;
    logic [PixW-1:0]  w0_q, w0_d, w1_q, w1_d, lb_rdata, pix_val;
    logic v0_q, v0_d, v1_q, v1_d, rvld_q, din_vld_q;
    logic [DinW-1:0] out_pix_q, out_pix_d;
    logic out_valid_q, out_valid_d, out_eol_q, out_eol_d;
    logic out_last_q, out_last_d, frame_done_q, frame_done_d;
    logic unused_din;

    assign unused_din = bus_io.din[DinW-1];

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFill;
            StFill:  if (din_vld_q && wr_col_q == LastCol) state_d = StEmit0;
            StEmit0: if (pass_end) state_d = StEmit1;
            StEmit1: if (pass_end) state_d = StFill;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fill    = (state_q == StFill);
        emit    = (state_q == StEmit0) || (state_q == StEmit1);
        rd_fifo = fill && (bus_io.data_count_r >= CountW'(2)) && (rd_cnt_q != NumCol);
    end

    always_comb begin
        odd = oc_q[0];
`ifdef UPSCALE_BILINEAR_H_EN
        need_nxt = odd && (oc_q[OcolW-1:1] != LastCol);
        pix_val  = need_nxt ? avg565(w0_q, w1_q) : w0_q;
`else
        need_nxt = 1'b0;
        pix_val  = w0_q;
`endif
        src_ok   = v0_q && (!need_nxt || v1_q);
        load     = emit && src_ok && (!out_valid_q || bus_io.out_ready);
        pass_end = load && (oc_q == LastOcol);
        sof      = (state_q == StEmit0) && (row_q == '0) && (oc_q == '0);

        rd_cnt_d = rd_fifo ? rd_cnt_q + ColW'(1) : rd_cnt_q;
        wr_col_d = wr_col_q;
        if (din_vld_q) begin
            wr_col_d = (wr_col_q == LastCol) ? '0 : wr_col_q + ColW'(1);
            if (wr_col_q == LastCol) rd_cnt_d = '0;
        end
        row_d = row_q;
        if (pass_end && state_q == StEmit1) begin
            row_d = (row_q == LastRow) ? '0 : row_q + RowW'(1);
        end
        oc_d = load ? (pass_end ? '0 : oc_q + OcolW'(1)) : oc_q;

        // Two-entry window p[k], p[k+1]; an odd output pixel retires p[k].
        w0_d = w0_q;
        w1_d = w1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        if (load && odd) begin
            w0_d = w1_q;
            v0_d = v1_q;
            v1_d = 1'b0;
        end
        if (rvld_q) begin
            if (!v0_d) begin
                w0_d = lb_rdata;
                v0_d = 1'b1;
            end else begin
                w1_d = lb_rdata;
                v1_d = 1'b1;
            end
        end
        lb_re = emit && (fa_q != NumCol) && !(v0_d && v1_d);
        fa_d  = lb_re ? fa_q + ColW'(1) : fa_q;
        if (pass_end) begin
            fa_d = '0;
            v0_d = 1'b0;
            v1_d = 1'b0;
        end

        out_pix_d   = out_pix_q;
        out_eol_d   = out_eol_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_pix_d   = {sof, pix_val};
            out_eol_d   = (oc_q == LastOcol);
            out_last_d  = pass_end && (state_q == StEmit1) && (row_q == LastRow);
            out_valid_d = 1'b1;
        end else if (bus_io.out_ready) begin
            out_valid_d = 1'b0;
        end
        frame_done_d = out_valid_q && bus_io.out_ready && out_last_q;
    end

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q     <= '0;
            wr_col_q     <= '0;
            fa_q         <= '0;
            row_q        <= '0;
            oc_q         <= '0;
            w0_q         <= '0;
            w1_q         <= '0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            rvld_q       <= 1'b0;
            din_vld_q    <= 1'b0;
            out_pix_q    <= '0;
            out_valid_q  <= 1'b0;
            out_eol_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            wr_col_q     <= wr_col_d;
            fa_q         <= fa_d;
            row_q        <= row_d;
            oc_q         <= oc_d;
            w0_q         <= w0_d;
            w1_q         <= w1_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            rvld_q       <= lb_re;
            din_vld_q    <= rd_fifo;
            out_pix_q    <= out_pix_d;
            out_valid_q  <= out_valid_d;
            out_eol_q    <= out_eol_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    line_buffer #(
        .Depth (IN_W),
        .AddrW (ColW),
        .DataW (PixW)
    ) u_line_buffer (
        .clk_i   (clk_r),
        .we_i    (din_vld_q),
        .waddr_i (wr_col_q),
        .wdata_i (bus_io.din[PixW-1:0]),
        .re_i    (lb_re),
        .raddr_i (fa_q),
        .rdata_o (lb_rdata)
    );

    assign bus_io.rd_fifo    = rd_fifo;
    assign bus_io.out_pix    = out_pix_q;
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.out_eol    = out_eol_q;
    assign bus_io.frame_done = frame_done_q;

endmodule

// File: tb/tb_upscale_2x.sv
// Scoreboard bench for upscale_2x on an 8x4 input frame; honours UPSCALE_BILINEAR_H_EN.
module tb_upscale_2x;

    localparam int unsigned InW      = 8;
    localparam int unsigned InH      = 4;
    localparam int unsigned OutW     = 2 * InW;
    localparam int unsigned FramePix = InW * InH;

    typedef struct packed {
        logic [16:0] pix;
        logic        eol;
        logic        last;
    } exp_t;

    exp_t sb[$];

    logic clk_r = 1'b0;
    logic rst_n = 1'b0;

    upscale_2x_if bus ();

    upscale_2x #(
        .IN_W (InW),
        .IN_H (InH)
    ) dut (
        .clk_r  (clk_r),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk_r = ~clk_r;

    int          total = 0;
    int          bad = 0;
    int unsigned rd_idx = 0;
    int          frames_done = 0;
    bit          rdy_rand = 1'b0;
    bit          hold_chk = 1'b0;
    bit          fd_exp = 1'b0;
    logic [16:0] prev_pix;
    logic        prev_eol;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Upstream stream content as a function of absolute read index; bit 16 is junk.
    function automatic logic [16:0] val(input int unsigned n);
        logic [31:0] h;
        h = n * 32'd40503 + 32'd7;
        return {h[20], h[15:0]};
    endfunction

    function automatic logic [15:0] mix(input logic [15:0] a, input logic [15:0] b);
        int r, g, bl;
        r  = (int'(a[15:11]) + int'(b[15:11])) / 2;
        g  = (int'(a[10:5]) + int'(b[10:5])) / 2;
        bl = (int'(a[4:0]) + int'(b[4:0])) / 2;
        return {r[4:0], g[5:0], bl[4:0]};
    endfunction

    task automatic push_frame(input int unsigned base);
        logic [15:0] p [InW];
        logic [16:0] v;
        exp_t e;
        int k;
        for (int r = 0; r < int'(InH); r++) begin
            for (int c = 0; c < int'(InW); c++) begin
                v = val(base + r * InW + c);
                p[c] = v[15:0];
            end
            for (int cp = 0; cp < 2; cp++) begin
                for (int oc = 0; oc < int'(OutW); oc++) begin
                    k = oc / 2;
                    e.pix[15:0] = p[k];
`ifdef UPSCALE_BILINEAR_H_EN
                    if ((oc % 2 == 1) && (k < int'(InW) - 1)) e.pix[15:0] = mix(p[k], p[k+1]);
`endif
                    e.pix[16] = (r == 0 && cp == 0 && oc == 0);
                    e.eol     = (oc == int'(OutW) - 1);
                    e.last    = (r == int'(InH) - 1 && cp == 1 && oc == int'(OutW) - 1);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (frames_done < target && n < 20000) begin
            @(posedge clk_r);
            n++;
        end
        check(tag, 32'(frames_done >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_fifo"}, 32'(bus.rd_fifo), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_eol"}, 32'(bus.out_eol), 32'd0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_out_pix"}, 32'(bus.out_pix), 32'd0);
    endtask

    // Upstream FIFO model: data appears one cycle after a sampled read strobe.
    initial begin
        bit rd_s;
        bus.din = '0;
        forever begin
            @(negedge clk_r);
            rd_s = bus.rd_fifo;
            @(posedge clk_r);
            #1;
            if (rd_s) begin
                bus.din = val(rd_idx);
                rd_idx++;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk_r);
            #1;
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk_r) begin
        exp_t e;
        if (!rst_n) begin
            hold_chk = 1'b0;
            fd_exp   = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_pix", 32'(bus.out_pix), 32'(prev_pix));
                check("hold_eol", 32'(bus.out_eol), 32'(prev_eol));
            end
            check("frame_done", 32'(bus.frame_done), 32'(fd_exp));
            if (bus.frame_done) frames_done++;
            fd_exp = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_pix", 32'(bus.out_pix), 32'(e.pix));
                    check("out_eol", 32'(bus.out_eol), 32'(e.eol));
                    fd_exp = e.last;
                end
            end
            hold_chk = bus.out_valid && !bus.out_ready;
            prev_pix = bus.out_pix;
            prev_eol = bus.out_eol;
        end
    end

    initial begin
        int unsigned base;
        int unsigned idx_hold;
        int n;
        bus.data_count_r = 10'd100;
        #12;
        check_reset_outputs("por");

        // Frames A..D back to back from the start of the stream.
        for (int f = 0; f < 4; f++) push_frame(f * FramePix);
        @(posedge clk_r);
        #3;
        rst_n = 1'b1;

        wait_frames(1, "frame_a");
        rdy_rand = 1'b1;
        wait_frames(2, "frame_b");

        // Frame C: starve the FIFO in the middle of input row 1.
        n = 0;
        while (rd_idx < 2 * FramePix + InW + 3 && n < 20000) begin
            @(negedge clk_r);
            n++;
        end
        check("pause_reached", 32'(rd_idx >= 2 * FramePix + InW + 3), 32'd1);
        @(posedge clk_r);
        #1;
        bus.data_count_r = 10'd1;
        @(posedge clk_r);
        #2;
        idx_hold = rd_idx;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_r);
            check("pause_rd_fifo", 32'(bus.rd_fifo), 32'd0);
        end
        check("pause_no_reads", rd_idx, idx_hold);
        @(posedge clk_r);
        #1;
        bus.data_count_r = 10'd50;
        wait_frames(3, "frame_c");
        rdy_rand = 1'b0;

        // Frame D: reset in the middle of input row 2.
        n = 0;
        while (rd_idx < 3 * FramePix + 2 * InW + 2 && n < 20000) begin
            @(negedge clk_r);
            n++;
        end
        check("reset_point_reached", 32'(rd_idx >= 3 * FramePix + 2 * InW + 2), 32'd1);
        @(posedge clk_r);
        #2;
        rst_n = 1'b0;
        base = rd_idx;
        #1;
        check_reset_outputs("mid_reset");
        sb.delete();
        for (int f = 0; f < 4; f++) push_frame(base + f * FramePix);
        repeat (2) @(posedge clk_r);
        #3;
        rst_n = 1'b1;

        wait_frames(4, "frame_e");
        rdy_rand = 1'b1;
        wait_frames(6, "frames_f_g");
        check("frames_total", 32'(frames_done), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
